// File: rtl/uart_pkt_tx.sv
// UART packet transmitter: header byte then 0..MAX_BYTES payload bytes as back-to-back 8N1 frames.
// Optional checksum byte (XOR of all sent bytes) under `UART_PKT_TX_CHECKSUM_EN.
module uart_pkt_tx #(
    parameter int MAX_PAYLD_PKT_BITS = 56,
    parameter int LEN_W              = 3
) (
    input  logic                          i_clk,
    input  logic                          n_btn_rst,
    input  logic [30:0]                   i_setup,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [7:0]                    i_cmd,
    input  logic [LEN_W-1:0]              i_len,
    input  logic [MAX_PAYLD_PKT_BITS-1:0] i_payload,
    output logic                          o_uart_tx,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int MAX_BYTES = MAX_PAYLD_PKT_BITS / 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                        state_q, state_d;
    logic [30:0]                   timer_q, timer_d;
    logic [30:0]                   setup_q, setup_d;
    logic [2:0]                    bit_q, bit_d;
    logic [LEN_W-1:0]              byte_q, byte_d;
    logic [LEN_W-1:0]              len_q, len_d;
    logic [MAX_PAYLD_PKT_BITS-1:0] pay_q, pay_d;
    logic [7:0]                    shift_q, shift_d;
    logic                          done_q, done_d;
`ifdef UART_PKT_TX_CHECKSUM_EN
    logic [7:0]                    csum_q, csum_d;
    logic                          ck_sent_q, ck_sent_d;
`endif

    logic [30:0]      setup_eff;
    logic [LEN_W-1:0] len_eff;
    logic             tick;

    assign setup_eff = (i_setup < 31'd2) ? 31'd2 : i_setup;
    assign len_eff   = (int'(i_len) > MAX_BYTES) ? LEN_W'(MAX_BYTES) : i_len;
    assign tick      = (timer_q == setup_q - 31'd1);

    always_ff @(posedge i_clk) begin
        if (!n_btn_rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            setup_q   <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            len_q     <= '0;
            pay_q     <= '0;
            shift_q   <= '0;
            done_q    <= 1'b0;
`ifdef UART_PKT_TX_CHECKSUM_EN
            csum_q    <= '0;
            ck_sent_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            setup_q   <= setup_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            len_q     <= len_d;
            pay_q     <= pay_d;
            shift_q   <= shift_d;
            done_q    <= done_d;
`ifdef UART_PKT_TX_CHECKSUM_EN
            csum_q    <= csum_d;
            ck_sent_q <= ck_sent_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        setup_d   = setup_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        len_d     = len_q;
        pay_d     = pay_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
`ifdef UART_PKT_TX_CHECKSUM_EN
        csum_d    = csum_q;
        ck_sent_d = ck_sent_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d   = START;
                    timer_d   = '0;
                    setup_d   = setup_eff;
                    bit_d     = '0;
                    byte_d    = '0;
                    len_d     = len_eff;
                    pay_d     = i_payload;
                    shift_d   = i_cmd;
`ifdef UART_PKT_TX_CHECKSUM_EN
                    csum_d    = i_cmd;
                    ck_sent_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick) begin
                    timer_d = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 31'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 31'd1;
                end
            end
            STOP: begin
                if (tick) begin
                    timer_d = '0;
                    // Next byte loads straight into START so frames abut with no idle gap.
                    if (byte_q < len_q) begin
                        shift_d = pay_q[7:0];
                        pay_d   = pay_q >> 8;
                        byte_d  = byte_q + 1'b1;
                        state_d = START;
`ifdef UART_PKT_TX_CHECKSUM_EN
                        csum_d  = csum_q ^ pay_q[7:0];
`endif
                    end
`ifdef UART_PKT_TX_CHECKSUM_EN
                    else if (!ck_sent_q) begin
                        shift_d   = csum_q;
                        ck_sent_d = 1'b1;
                        state_d   = START;
                    end
`endif
                    else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 31'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_uart_tx = 1'b1;
        case (state_q)
            START:   o_uart_tx = 1'b0;
            DATA:    o_uart_tx = shift_q[0];
            default: o_uart_tx = 1'b1;
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_pkt_tx.sv
module tb_uart_pkt_tx;

    typedef struct {
        logic [30:0] setup;
        logic [7:0]  cmd;
        logic [2:0]  len;
        logic [55:0] payload;
    } pkt_t;

    typedef struct {
        pkt_t p;
        int   exp_busy;
        bit   mutate;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        n_btn_rst = 1'b0;
    logic [30:0] i_setup = '0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_cmd = '0;
    logic [2:0]  i_len = '0;
    logic [55:0] i_payload = '0;
    logic        o_uart_tx;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    uart_pkt_tx dut (
        .i_clk(i_clk), .n_btn_rst(n_btn_rst), .i_setup(i_setup),
        .i_valid(i_valid), .o_ready(o_ready), .i_cmd(i_cmd), .i_len(i_len),
        .i_payload(i_payload), .o_uart_tx(o_uart_tx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: list the bytes, then expand each into 10 line levels of setup cycles.
    task automatic build_exp(input pkt_t p);
        int s;
        int n;
        logic [7:0] b[$];
        logic [7:0] x;
        logic v;
        s = (p.setup < 2) ? 2 : int'(p.setup);
        n = (p.len > 7) ? 7 : int'(p.len);
        b.delete();
        b.push_back(p.cmd);
        x = p.cmd;
        for (int k = 0; k < n; k++) begin
            b.push_back(p.payload[8*k +: 8]);
            x = x ^ p.payload[8*k +: 8];
        end
`ifdef UART_PKT_TX_CHECKSUM_EN
        b.push_back(x);
`endif
        exp_q.delete();
        foreach (b[i]) begin
            for (int j = -1; j <= 8; j++) begin
                v = (j < 0) ? 1'b0 : (j > 7) ? 1'b1 : b[i][j];
                for (int c = 0; c < s; c++) exp_q.push_back(v);
            end
        end
    endtask

    task automatic drive(input pkt_t p);
        i_setup   = p.setup;
        i_cmd     = p.cmd;
        i_len     = p.len;
        i_payload = p.payload;
    endtask

    task automatic start(input pkt_t p, input string name);
        drive(p);
        i_valid = 1'b1;
        check({name, "_ready_at_offer"}, o_ready, 1);
    endtask

    // Called at the negedge before the accepting edge; returns at the o_done-cycle negedge.
    task automatic monitor(input pkt_t p, input bit chain, input pkt_t nxt,
                           input bit mutate, input string name);
        int cyc;
        int line_err;
        int early;
        build_exp(p);
        @(negedge i_clk);
        if (chain) drive(nxt);
        else i_valid = 1'b0;
        cyc = 0; line_err = 0; early = 0;
        while (o_busy && cyc < 2000) begin
            if (cyc >= exp_q.size() || o_uart_tx !== exp_q[cyc]) line_err++;
            if (o_done || o_ready) early++;
            if (mutate && cyc == exp_q.size() / 2) begin
                i_payload = {$urandom, $urandom};
                i_cmd     = 8'($urandom);
                i_len     = 3'($urandom);
                i_setup   = 31'($urandom_range(0, 9));
            end
            cyc++;
            @(negedge i_clk);
        end
        check({name, "_busy_cycles"}, cyc, exp_q.size());
        check({name, "_line_errs"}, line_err, 0);
        check({name, "_early_done_or_ready"}, early, 0);
        check({name, "_done_pulse"}, o_done, 1);
        check({name, "_ready_in_done"}, o_ready, 1);
    endtask

    task automatic run(input pkt_t p, input bit mutate, input string name);
        pkt_t dummy;
        dummy = p;
        start(p, name);
        monitor(p, 1'b0, dummy, mutate, name);
        @(negedge i_clk);
        check({name, "_done_one_cycle"}, o_done, 0);
        check({name, "_idle_line"}, o_uart_tx, 1);
    endtask

    function automatic pkt_t rand_pkt();
        pkt_t p;
        p.setup   = 31'($urandom_range(0, 5));
        p.cmd     = 8'($urandom);
        p.len     = 3'($urandom);
        p.payload = {$urandom, $urandom};
        return p;
    endfunction

    vec_t vecs[5];
    localparam int XB = 0
`ifdef UART_PKT_TX_CHECKSUM_EN
        + 1
`endif
        ;

    initial begin
        pkt_t p, n;
        int bad;
        bit ch;

        vecs[0] = '{'{31'd4, 8'hA5, 3'd0, 56'h0},                 (1+0+XB)*10*4, 1'b0};
        vecs[1] = '{'{31'd3, 8'h02, 3'd2, 56'h0000_0000_0000_3C81}, (1+2+XB)*10*3, 1'b0};
        vecs[2] = '{'{31'd2, 8'h7E, 3'd7, 56'h11_2233_4455_6677},  (1+7+XB)*10*2, 1'b1};
        vecs[3] = '{'{31'd0, 8'h5A, 3'd1, 56'hC3},                 (1+1+XB)*10*2, 1'b0};
        vecs[4] = '{'{31'd1, 8'hFF, 3'd3, 56'h00_0000_0080_0001},  (1+3+XB)*10*2, 1'b1};

        repeat (5) @(negedge i_clk);
        n_btn_rst = 1'b1;
        @(negedge i_clk);
        check("reset_line", o_uart_tx, 1);
        check("reset_ready", o_ready, 1);
        check("reset_busy", o_busy, 0);
        check("reset_done", o_done, 0);
        bad = 0;
        repeat (100) begin
            @(negedge i_clk);
            if (o_uart_tx !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) bad++;
        end
        check("idle_100_cycles", bad, 0);

        // Header-only line pattern spelled out literally.
        begin
            logic [9:0] pat;
            pat = 10'b11_0100_1010;
            build_exp(vecs[0].p);
            bad = 0;
            for (int i = 0; i < 40; i++) if (exp_q[i] !== pat[i/4]) bad++;
            check("model_a5_pattern", bad, 0);
        end

        for (int i = 0; i < 5; i++) begin
            build_exp(vecs[i].p);
            check($sformatf("vec%0d_table_len", i), exp_q.size(), vecs[i].exp_busy);
            run(vecs[i].p, vecs[i].mutate, $sformatf("vec%0d", i));
        end

        // Back-to-back: second packet waiting with i_valid held high.
        p = vecs[3].p;
        n = vecs[1].p;
        start(p, "b2b_a");
        monitor(p, 1'b1, n, 1'b0, "b2b_a");
        monitor(n, 1'b0, n, 1'b0, "b2b_b");
        @(negedge i_clk);
        check("b2b_done_one_cycle", o_done, 0);

        // Reset during DATA bit 3 of payload byte 1 (byte index 2).
        p = '{31'd3, 8'h33, 3'd3, 56'h00_0000_00A6_5C11};
        build_exp(p);
        start(p, "rst_mid");
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (72) @(negedge i_clk);
        check("rst_mid_line_before", o_uart_tx, exp_q[72]);
        check("rst_mid_busy_before", o_busy, 1);
        n_btn_rst = 1'b0;
        @(negedge i_clk);
        n_btn_rst = 1'b1;
        check("rst_mid_line", o_uart_tx, 1);
        check("rst_mid_ready", o_ready, 1);
        check("rst_mid_busy", o_busy, 0);
        bad = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_done !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        check("rst_mid_no_done", bad, 0);
        run(vecs[1].p, 1'b0, "after_rst");

        // Random packets, some chained back-to-back, some with inputs disturbed mid-flight.
        p = rand_pkt();
        start(p, "rand");
        for (int i = 0; i < 20; i++) begin
            n = rand_pkt();
            ch = (i < 19) && ($urandom_range(0, 1) == 1);
            monitor(p, ch, n, !ch && ($urandom_range(0, 1) == 1), $sformatf("rand%0d", i));
            if (!ch) begin
                @(negedge i_clk);
                check($sformatf("rand%0d_done_one_cycle", i), o_done, 0);
                repeat ($urandom_range(0, 3)) @(negedge i_clk);
                if (i < 19) start(n, $sformatf("rand%0d", i + 1));
            end
            p = n;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
